tlk2711_rd_sched: RTL and testbench
===================================

TLK2711_RD_SCHED -- requirements
Module: tlk2711_rd_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, DMA byte-address width.
REQ-002 SHALL have parameter DLEN_WIDTH, default 16, per-command byte-length width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, accepted-but-uncompleted command limit (1..15).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  transfer start pulse.
- i_base_addr  in  ADDR_WIDTH  transfer start byte address.
- i_total_len  in  32  transfer total byte count.
- i_chunk_len  in  DLEN_WIDTH  maximum bytes per command.
- i_abort  in  1  stop issuing, then drain.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle rejected-start pulse.
- o_rd_cmd_data  out  DLEN_WIDTH+ADDR_WIDTH  {address (high), byte length (low)}.
- o_rd_cmd_req  out  1  command valid.
- i_rd_cmd_ack  in  1  command accepted (transfer on req&ack).
- i_rd_last  in  1  one-cycle pulse per completed read command.
- o_cmd_cnt  out  16  issued-command count (present only with TLK2711_RD_SCHED_STATS_EN).

Function
REQ-005 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-006 IDLE: i_start with i_total_len!=0 and i_chunk_len!=0 SHALL latch address, remaining=i_total_len, chunk, and enter ISSUE next cycle; o_busy high from that cycle.
REQ-007 IDLE: i_start with zero total or zero chunk SHALL pulse o_err one cycle later, issue nothing, stay IDLE.
REQ-008 i_start outside IDLE SHALL be ignored.
REQ-009 Command length SHALL be min(remaining, chunk); address SHALL be base plus bytes already issued, modulo 2^ADDR_WIDTH.
REQ-010 ISSUE: o_rd_cmd_req SHALL assert only while outstanding < MAX_OUTSTANDING; o_rd_cmd_req is registered; first req rises the cycle after IDLE->ISSUE.
REQ-011 Once o_rd_cmd_req is high, it and o_rd_cmd_data SHALL hold stable until the req&ack cycle.
REQ-012 On req&ack: remaining -= length, address += length, outstanding += 1; next command may be presented the following cycle (one command per two cycles minimum not required; back-to-back accepted).
REQ-013 i_rd_last with outstanding>0 SHALL decrement outstanding; i_rd_last with outstanding==0 SHALL be ignored.
REQ-014 Same-cycle req&ack and i_rd_last SHALL leave outstanding unchanged.
REQ-015 ISSUE SHALL enter DRAIN after the handshake that makes remaining 0.
REQ-016 i_abort in ISSUE SHALL enter DRAIN immediately if o_rd_cmd_req is low, else after the pending handshake completes; i_abort in other states ignored.
REQ-017 DRAIN SHALL enter DONE when outstanding==0 (including the cycle i_rd_last clears it).
REQ-018 DONE SHALL last one cycle with o_done high, then IDLE; o_busy low in IDLE only.
REQ-019 Arithmetic: remaining 32-bit unsigned, never wraps below 0; outstanding 4-bit.

Reset
REQ-020 rst SHALL force IDLE, o_rd_cmd_req=0, o_rd_cmd_data=0, o_busy=0, o_done=0, o_err=0, outstanding=0, o_cmd_cnt=0, effective next edge.
REQ-021 rst mid-transfer SHALL drop o_rd_cmd_req without waiting for ack; later i_rd_last pulses are ignored.

Configuration
REQ-022 With TLK2711_RD_SCHED_STATS_EN defined, o_cmd_cnt SHALL count req&ack handshakes, cleared on rst and on accepted i_start, saturating at 16'hFFFF.
REQ-023 Without TLK2711_RD_SCHED_STATS_EN, port o_cmd_cnt and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-024 State encoding, MAX_OUTSTANDING default and status/state widths SHALL live in shared package tlk2711_dma_pkg.
REQ-025 Block SHALL be flat; no sub-module.

Verification
REQ-026 base=0x1000_0000, total=0x5000, chunk=0x2000, ack same cycle as req, last 10 cycles after ack -> commands {0x1000_0000,0x2000},{0x1000_2000,0x2000},{0x1000_4000,0x1000}; one o_done after third last.
REQ-027 MAX_OUTSTANDING=2, total=0x8000, chunk=0x1000, no i_rd_last for 50 cycles -> exactly 2 handshakes, then req low until first last.
REQ-028 ack held low 20 cycles with req high -> o_rd_cmd_data stable all 20 cycles; i_abort on cycle 5 -> DRAIN only after the handshake.
REQ-029 i_start with total=0 -> o_err one cycle, o_rd_cmd_req never high, o_busy stays 0.
REQ-030 base=0xFFFF_F000, total=0x2000, chunk=0x1000 -> second address 0x0000_0000.
REQ-031 rst asserted with 2 outstanding, then new start -> clean run, stale i_rd_last ignored, o_cmd_cnt restarts at 0 (macro defined).

Source files
------------

// File: rtl/tlk2711_dma_pkg.sv
// Shared definitions for the TLK2711 DMA read path: scheduler state encoding,
// status/state widths and the outstanding-command default.
package tlk2711_dma_pkg;

  localparam int STATE_W             = 2;
  localparam int OUTSTANDING_W       = 4;
  localparam int TOTAL_LEN_W         = 32;
  localparam int CMD_CNT_W           = 16;
  localparam int MAX_OUTSTANDING_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  function automatic logic [TOTAL_LEN_W-1:0] min_len(
    input logic [TOTAL_LEN_W-1:0] a,
    input logic [TOTAL_LEN_W-1:0] b
  );
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/tlk2711_rd_sched.sv
// Splits a DMA read transfer into chunk-sized commands with a cap on outstanding reads.
// Optional issued-command counter on o_cmd_cnt when TLK2711_RD_SCHED_STATS_EN is defined.
module tlk2711_rd_sched
  import tlk2711_dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DLEN_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [TOTAL_LEN_W-1:0]           i_total_len,
  input  logic [DLEN_WIDTH-1:0]            i_chunk_len,
  input  logic                             i_abort,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
  output logic                             o_rd_cmd_req,
  input  logic                             i_rd_cmd_ack,
  input  logic                             i_rd_last
`ifdef TLK2711_RD_SCHED_STATS_EN
  ,
  output logic [CMD_CNT_W-1:0]             o_cmd_cnt
`endif
);

  localparam logic [OUTSTANDING_W-1:0] MAX_OUT = OUTSTANDING_W'(MAX_OUTSTANDING);

  rd_state_t                       state_r, state_s;
  logic [ADDR_WIDTH-1:0]           addr_r, addr_s;
  logic [TOTAL_LEN_W-1:0]          remaining_r, rem_s;
  logic [DLEN_WIDTH-1:0]           chunk_r;
  logic [OUTSTANDING_W-1:0]        outstanding_r, outstanding_s;
  logic                            abort_pend_r, abort_pend_s;
  logic                            req_r, req_s;
  logic [DLEN_WIDTH+ADDR_WIDTH-1:0] data_r, data_s;
  logic                            busy_r, done_r, err_r, err_s;
  logic                            accept_s, hs_s, last_ok_s, can_issue_s;
  logic [DLEN_WIDTH-1:0]           cur_len_s, next_len_s;

  assign hs_s      = req_r & i_rd_cmd_ack;
  assign last_ok_s = i_rd_last & (outstanding_r != 4'd0);
  assign cur_len_s = data_r[DLEN_WIDTH-1:0];

  // Address/remaining after this cycle's handshake; the next command is built from these.
  always_comb begin
    addr_s = addr_r;
    rem_s  = remaining_r;
    if (hs_s) begin
      addr_s = addr_r + ADDR_WIDTH'(cur_len_s);
      rem_s  = remaining_r - TOTAL_LEN_W'(cur_len_s);
    end else begin
      addr_s = addr_r;
      rem_s  = remaining_r;
    end
    next_len_s = DLEN_WIDTH'(min_len(rem_s, TOTAL_LEN_W'(chunk_r)));
  end

  // Outstanding count: an accept and a completion in the same cycle cancel out.
  always_comb begin
    outstanding_s = outstanding_r;
    case ({hs_s, last_ok_s})
      2'b10:   outstanding_s = outstanding_r + 4'd1;
      2'b01:   outstanding_s = outstanding_r - 4'd1;
      default: outstanding_s = outstanding_r;
    endcase
    can_issue_s = (outstanding_s < MAX_OUT);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_s      = state_r;
    req_s        = req_r;
    data_s       = data_r;
    abort_pend_s = abort_pend_r;
    err_s        = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          if ((i_total_len != 32'd0) && (i_chunk_len != '0)) begin
            state_s      = ST_ISSUE;
            accept_s     = 1'b1;
            abort_pend_s = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hs_s) begin
          // An abort seen while req was up takes effect once this handshake lands.
          if ((rem_s == 32'd0) || abort_pend_r || i_abort) begin
            state_s      = ST_DRAIN;
            req_s        = 1'b0;
            abort_pend_s = 1'b0;
          end else if (can_issue_s) begin
            req_s  = 1'b1;
            data_s = {addr_s, next_len_s};
          end else begin
            req_s = 1'b0;
          end
        end else if (req_r) begin
          if (i_abort) begin
            abort_pend_s = 1'b1;
          end else begin
            abort_pend_s = abort_pend_r;
          end
        end else if (i_abort) begin
          state_s = ST_DRAIN;
        end else if (can_issue_s) begin
          req_s  = 1'b1;
          data_s = {addr_s, next_len_s};
        end else begin
          req_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (outstanding_s == 4'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      remaining_r   <= 32'd0;
      chunk_r       <= '0;
      outstanding_r <= 4'd0;
      abort_pend_r  <= 1'b0;
      req_r         <= 1'b0;
      data_r        <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      outstanding_r <= outstanding_s;
      abort_pend_r  <= abort_pend_s;
      req_r         <= req_s;
      data_r        <= data_s;
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= (state_s == ST_DONE);
      err_r         <= err_s;
      if (accept_s) begin
        addr_r      <= i_base_addr;
        remaining_r <= i_total_len;
        chunk_r     <= i_chunk_len;
      end else begin
        addr_r      <= addr_s;
        remaining_r <= rem_s;
        chunk_r     <= chunk_r;
      end
    end
  end

`ifdef TLK2711_RD_SCHED_STATS_EN
  logic [CMD_CNT_W-1:0] cmd_cnt_r;

  // Saturating handshake counter, restarted by each accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt_r <= 16'd0;
    end else if (accept_s) begin
      cmd_cnt_r <= 16'd0;
    end else if (hs_s && (cmd_cnt_r != 16'hFFFF)) begin
      cmd_cnt_r <= cmd_cnt_r + 16'd1;
    end else begin
      cmd_cnt_r <= cmd_cnt_r;
    end
  end

  assign o_cmd_cnt = cmd_cnt_r;
`endif

  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_err         = err_r;
  assign o_rd_cmd_req  = req_r;
  assign o_rd_cmd_data = data_r;

endmodule

// File: tb/tb_tlk2711_rd_sched.sv
// Directed bench for tlk2711_rd_sched: a command-list / outstanding-count model checked every cycle,
// plus literal expectations for the reference transfers.
module tb_tlk2711_rd_sched;
  localparam int AW       = 32;
  localparam int DW       = 16;
  localparam int MAXO     = 2;
  localparam int LAST_DLY = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [AW-1:0]     i_base_addr;
  logic [31:0]       i_total_len;
  logic [DW-1:0]     i_chunk_len;
  logic              i_abort;
  logic              o_busy, o_done, o_err, o_rd_cmd_req;
  logic [DW+AW-1:0]  o_rd_cmd_data;
  logic              i_rd_cmd_ack = 1'b0;
  logic              i_rd_last = 1'b0;
`ifdef TLK2711_RD_SCHED_STATS_EN
  logic [15:0]       o_cmd_cnt;
`endif

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int model_out = 0;
  logic ack_en = 1'b1;
  logic last_auto = 1'b1;
  logic last_man = 1'b0;
  logic [DW+AW-1:0] exp_q[$];
  logic [DW+AW-1:0] cap_q[$];
  int tq[$];
  logic prev_req = 1'b0, prev_hs = 1'b0, prev_done = 1'b0;
  logic [DW+AW-1:0] prev_data = '0;

  tlk2711_rd_sched #(.ADDR_WIDTH(AW), .DLEN_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
`ifdef TLK2711_RD_SCHED_STATS_EN
    .o_cmd_cnt(o_cmd_cnt),
`endif
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_total_len(i_total_len), .i_chunk_len(i_chunk_len), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd_cmd_data(o_rd_cmd_data),
    .o_rd_cmd_req(o_rd_cmd_req), .i_rd_cmd_ack(i_rd_cmd_ack), .i_rd_last(i_rd_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Expected command list from the transfer parameters alone.
  task automatic do_start(input logic [31:0] base, input logic [31:0] tot, input logic [15:0] chunk);
    logic [31:0] a, r, l;
    exp_q.delete();
    cap_q.delete();
    hs_cnt = 0;
    done_cnt = 0;
    a = base;
    r = (chunk == 16'd0) ? 32'd0 : tot;
    while (r != 32'd0) begin
      l = (r < {16'd0, chunk}) ? r : {16'd0, chunk};
      exp_q.push_back({a, l[15:0]});
      a = a + l;
      r = r - l;
    end
    tick();
    i_start = 1'b1; i_base_addr = base; i_total_len = tot; i_chunk_len = chunk;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      sample();
      n++;
    end
    chk(nm, 64'(done_cnt), 64'd1);
  endtask

  // Ack responder and delayed completion pulses.
  initial begin
    bit fire;
    forever begin
      @(posedge clk);
      #2;
      i_rd_cmd_ack = ack_en && o_rd_cmd_req;
      fire = 1'b0;
      foreach (tq[i]) tq[i] = tq[i] - 1;
      if (tq.size() != 0 && tq[0] <= 0) begin
        fire = 1'b1;
        void'(tq.pop_front());
      end
      i_rd_last = fire || last_man;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic hs;
    if (rst) begin
      exp_q.delete();
      model_out = 0;
      prev_req = 1'b0; prev_hs = 1'b0; prev_done = 1'b0;
    end else begin
      hs = o_rd_cmd_req && i_rd_cmd_ack;
      if (o_rd_cmd_req) begin
        chk("req_within_limit", 64'(model_out < MAXO), 64'd1);
        chk("busy_with_req", 64'(o_busy), 64'd1);
      end
      if (prev_req && !prev_hs) begin
        chk("req_hold", 64'(o_rd_cmd_req), 64'd1);
        chk("data_hold", 64'(o_rd_cmd_data), 64'(prev_data));
      end
      if (hs) begin
        chk("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("cmd_data", 64'(o_rd_cmd_data), 64'(exp_q.pop_front()));
        cap_q.push_back(o_rd_cmd_data);
        hs_cnt++;
        if (last_auto) tq.push_back(LAST_DLY);
      end
      if (prev_done) chk("done_one_cycle", 64'(o_done), 64'd0);
      if (o_done) begin
        chk("done_drained", 64'(model_out), 64'd0);
        done_cnt++;
      end
      model_out = model_out + (hs ? 1 : 0) - ((i_rd_last && model_out > 0) ? 1 : 0);
      prev_req = o_rd_cmd_req; prev_hs = hs; prev_data = o_rd_cmd_data; prev_done = o_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rq;
    logic [DW+AW-1:0] d0;
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_base_addr = '0; i_total_len = 32'd0; i_chunk_len = '0;
    repeat (3) tick();
    rst = 1'b0;
    sample();
    chk("rst_req", 64'(o_rd_cmd_req), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_data", 64'(o_rd_cmd_data), 64'd0);
`ifdef TLK2711_RD_SCHED_STATS_EN
    chk("rst_cnt", 64'(o_cmd_cnt), 64'd0);
`endif

    // Reference three-command transfer.
    do_start(32'h1000_0000, 32'h0000_5000, 16'h2000);
    sample();
    chk("busy_after_start", 64'(o_busy), 64'd1);
    chk("req_not_yet", 64'(o_rd_cmd_req), 64'd0);
    sample();
    chk("first_req", 64'(o_rd_cmd_req), 64'd1);
    wait_done(200, "t1_done");
    chk("t1_hs", 64'(hs_cnt), 64'd3);
    chk("t1_left", 64'(exp_q.size()), 64'd0);
    if (cap_q.size() >= 3) begin
      chk("t1_cmd0", 64'(cap_q[0]), 64'h1000_0000_2000);
      chk("t1_cmd1", 64'(cap_q[1]), 64'h1000_2000_2000);
      chk("t1_cmd2", 64'(cap_q[2]), 64'h1000_4000_1000);
    end
`ifdef TLK2711_RD_SCHED_STATS_EN
    chk("t1_cnt", 64'(o_cmd_cnt), 64'd3);
`endif
    sample();
    chk("t1_busy_low", 64'(o_busy), 64'd0);
    chk("t1_single_done", 64'(done_cnt), 64'd1);

    // Rejected starts.
    tick();
    i_start = 1'b1; i_total_len = 32'd0; i_chunk_len = 16'h0100;
    tick();
    i_start = 1'b0;
    sample();
    chk("err_pulse", 64'(o_err), 64'd1);
    chk("err_busy", 64'(o_busy), 64'd0);
    sample();
    chk("err_one_cycle", 64'(o_err), 64'd0);
    tick();
    i_start = 1'b1; i_total_len = 32'h100; i_chunk_len = 16'h0000;
    tick();
    i_start = 1'b0;
    sample();
    chk("err_chunk0", 64'(o_err), 64'd1);
    rq = 0;
    repeat (10) begin
      sample();
      if (o_rd_cmd_req || o_busy) rq++;
    end
    chk("err_no_activity", 64'(rq), 64'd0);

    // Outstanding limit with completions withheld, then abort while req is low.
    last_auto = 1'b0;
    do_start(32'h2000_0000, 32'h0000_8000, 16'h1000);
    repeat (50) sample();
    chk("maxo_hs", 64'(hs_cnt), 64'd2);
    chk("maxo_req_low", 64'(o_rd_cmd_req), 64'd0);
    tick(); last_man = 1'b1;
    tick(); last_man = 1'b0;
    n = 0;
    while (hs_cnt < 3 && n < 10) begin sample(); n++; end
    chk("req_after_last", 64'(hs_cnt), 64'd3);
    tick(); i_abort = 1'b1;
    tick(); i_abort = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 40) begin
      tick(); last_man = 1'b1;
      tick(); last_man = 1'b0;
      n++;
    end
    sample();
    chk("abort_done", 64'(done_cnt), 64'd1);
    chk("abort_no_more_cmds", 64'(hs_cnt), 64'd3);
    last_auto = 1'b1;
    repeat (3) sample();

    // Ack held off for 20 cycles, abort arriving while req waits.
    ack_en = 1'b0;
    do_start(32'h3000_0000, 32'h0000_3000, 16'h1000);
    n = 0;
    while (!o_rd_cmd_req && n < 20) begin sample(); n++; end
    d0 = o_rd_cmd_data;
    chk("hold_first_data", 64'(d0), 64'h3000_0000_1000);
    for (int k = 0; k < 20; k++) begin
      tick();
      i_abort = (k == 5);
      sample();
      chk("stall_req", 64'(o_rd_cmd_req), 64'd1);
      chk("stall_data", 64'(o_rd_cmd_data), 64'(d0));
    end
    tick();
    i_abort = 1'b0;
    ack_en = 1'b1;
    wait_done(100, "stall_done");
    chk("stall_hs", 64'(hs_cnt), 64'd1);
    repeat (3) sample();

    // Address wrap at the top of the address space.
    do_start(32'hFFFF_F000, 32'h0000_2000, 16'h1000);
    wait_done(100, "wrap_done");
    chk("wrap_hs", 64'(hs_cnt), 64'd2);
    if (cap_q.size() >= 2) chk("wrap_cmd1", 64'(cap_q[1]), 64'h0000_0000_1000);
    repeat (3) sample();

    // Reset with commands outstanding, stale completions, then a clean run.
    do_start(32'h4000_0000, 32'h0000_4000, 16'h1000);
    n = 0;
    while (hs_cnt < 2 && n < 20) begin sample(); n++; end
    chk("pre_rst_hs", 64'(hs_cnt), 64'd2);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    sample();
    chk("mid_rst_req", 64'(o_rd_cmd_req), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
`ifdef TLK2711_RD_SCHED_STATS_EN
    chk("mid_rst_cnt", 64'(o_cmd_cnt), 64'd0);
`endif
    repeat (15) sample();
    chk("stale_last_idle", 64'(o_busy), 64'd0);
    do_start(32'h5000_0000, 32'h0000_2000, 16'h1000);
    wait_done(100, "post_rst_done");
    chk("post_rst_hs", 64'(hs_cnt), 64'd2);
    chk("post_rst_left", 64'(exp_q.size()), 64'd0);
    if (cap_q.size() >= 1) chk("post_rst_cmd0", 64'(cap_q[0]), 64'h5000_0000_1000);
`ifdef TLK2711_RD_SCHED_STATS_EN
    chk("post_rst_cnt", 64'(o_cmd_cnt), 64'd2);
`endif
    repeat (3) sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
